// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control slice.
package lc3b_types;

  // RUN is normal flow; DISCARD drops one stale instruction fetch after a redirect.
  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } pipe_ctrl_state_t;

  // The MEM stage is waiting on data memory, so the whole pipe must hold.
  function automatic logic dmemFreeze(input logic req, input logic resp);
    return req & ~resp;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;

  // Count enabled cycles and stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: stage load enables, bubble flushes,
// branch redirect and stall/flush event counters.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_resp,
  input  logic          dmem_req,
  input  logic          dmem_resp,
  input  logic          load_use,
  input  logic          mispredict,
  output logic          load_pc,
  output logic          load_if_id,
  output logic          load_id_ex,
  output logic          load_ex_mem,
  output logic          load_mem_wb,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_ex_mem,
  output logic          pc_redirect,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_nextState;
  logic             w_freeze;
  logic             w_stallEn;

  assign w_freeze = dmemFreeze(dmem_req, dmem_resp);

  // State register; reset abandons any pending discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Hazard priority: reset, dmem freeze, mispredict, load-use, then fetch wait / discard.
  always_comb begin
    w_nextState  = r_state;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_redirect  = 1'b0;

    if (reset) begin
      w_nextState  = RUN;
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (w_freeze) begin
      // Everything holds, including a mispredicting branch sitting in EX/MEM,
      // so the redirect simply happens once the freeze lifts.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      if ((r_state == DISCARD) && imem_resp) begin
        w_nextState = RUN;
      end
    end else if (mispredict) begin
      pc_redirect  = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      // A fetch still outstanding from the wrong path must be thrown away.
      if ((r_state == RUN) && !imem_resp) begin
        w_nextState = DISCARD;
      end
    end else begin
      if (load_use) begin
        // Hold PC and IF/ID (no IF/ID flush, or the held instruction is lost).
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        flush_id_ex = 1'b1;
      end else if ((r_state == DISCARD) || !imem_resp) begin
        load_pc     = 1'b0;
        flush_if_id = 1'b1;
      end
      if ((r_state == DISCARD) && imem_resp) begin
        w_nextState = RUN;
      end
    end
  end

  assign w_stallEn = ~reset & ~load_pc;

  sat_counter #(.CW(CW)) u_stall_count (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_stallEn),
    .o_count (stall_count)
  );

  sat_counter #(.CW(CW)) u_flush_count (
    .clk     (clk),
    .reset   (reset),
    .i_en    (pc_redirect),
    .o_count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected controls and counters are
// queued when each cycle's inputs are driven and popped when sampled.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0] loads;    // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0] flushes;  // if_id, id_ex, ex_mem
    logic       redir;
  } ctrl_t;

  localparam ctrl_t C_NORM   = ctrl_t'(9'b11111_000_0);
  localparam ctrl_t C_FREEZE = ctrl_t'(9'b00000_000_0);
  localparam ctrl_t C_MISP   = ctrl_t'(9'b11111_111_1);
  localparam ctrl_t C_LU     = ctrl_t'(9'b00111_010_0);
  localparam ctrl_t C_IWAIT  = ctrl_t'(9'b01111_100_0);
  localparam ctrl_t C_DISC   = ctrl_t'(9'b01111_100_0);
  localparam ctrl_t C_RST    = ctrl_t'(9'b00000_111_0);

  // Event encoding: {reset, imem_resp, dmem_req, dmem_resp, load_use, mispredict}
  localparam logic [5:0] E_RST  = 6'b100000;
  localparam logic [5:0] E_IMEM = 6'b010000;
  localparam logic [5:0] E_DREQ = 6'b001000;
  localparam logic [5:0] E_DRSP = 6'b000100;
  localparam logic [5:0] E_LU   = 6'b000010;
  localparam logic [5:0] E_MISP = 6'b000001;
  localparam logic [5:0] E_NONE = 6'b000000;

  logic        clk;
  logic        reset;
  logic        imemResp;
  logic        dmemReq;
  logic        dmemResp;
  logic        loadUse;
  logic        mispredict;
  logic        loadPc;
  logic        loadIfId;
  logic        loadIdEx;
  logic        loadExMem;
  logic        loadMemWb;
  logic        flushIfId;
  logic        flushIdEx;
  logic        flushExMem;
  logic        pcRedirect;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  int          vectors;
  int          miscompares;
  ctrl_t       expQ[$];
  logic [15:0] stallQ[$];
  logic [15:0] flushQ[$];
  logic [15:0] stallModel;
  logic [15:0] flushModel;

  pipeline_ctrl #(.CW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_resp    (imemResp),
    .dmem_req     (dmemReq),
    .dmem_resp    (dmemResp),
    .load_use     (loadUse),
    .mispredict   (mispredict),
    .load_pc      (loadPc),
    .load_if_id   (loadIfId),
    .load_id_ex   (loadIdEx),
    .load_ex_mem  (loadExMem),
    .load_mem_wb  (loadMemWb),
    .flush_if_id  (flushIfId),
    .flush_id_ex  (flushIdEx),
    .flush_ex_mem (flushExMem),
    .pc_redirect  (pcRedirect),
    .stall_count  (stallCount),
    .flush_count  (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t actualCtrl();
    return {loadPc, loadIfId, loadIdEx, loadExMem, loadMemWb,
            flushIfId, flushIdEx, flushExMem, pcRedirect};
  endfunction

  // Drive one cycle of inputs and queue what the controller should do with them.
  task automatic applyStimulus(input logic [5:0] ev, input ctrl_t exp);
    reset      = ev[5];
    imemResp   = ev[4];
    dmemReq    = ev[3];
    dmemResp   = ev[2];
    loadUse    = ev[1];
    mispredict = ev[0];
    expQ.push_back(exp);
    if (ev[5]) begin
      stallModel = '0;
      flushModel = '0;
    end else begin
      if (!exp.loads[4] && (stallModel != 16'hFFFF)) stallModel = stallModel + 16'd1;
      if (exp.redir && (flushModel != 16'hFFFF)) flushModel = flushModel + 16'd1;
    end
    stallQ.push_back(stallModel);
    flushQ.push_back(flushModel);
  endtask

  task automatic test_reset();
    logic [5:0] ev [5] = '{E_RST, E_RST, E_IMEM, E_IMEM, E_IMEM};
    ctrl_t      ex [5] = '{C_RST, C_RST, C_NORM, C_NORM, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL reset ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL reset counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    logic [5:0] ev [4] = '{E_IMEM|E_DREQ, E_IMEM|E_DREQ, E_IMEM|E_DREQ, E_IMEM|E_DREQ|E_DRSP};
    ctrl_t      ex [4] = '{C_FREEZE, C_FREEZE, C_FREEZE, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL freeze ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL freeze counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    logic [5:0] ev [3] = '{E_IMEM|E_LU, E_NONE, E_IMEM};
    ctrl_t      ex [3] = '{C_LU, C_IWAIT, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL load_use ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL load_use counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mispredict_discard();
    logic [5:0] ev [5] = '{E_MISP, E_NONE, E_NONE, E_IMEM, E_IMEM};
    ctrl_t      ex [5] = '{C_MISP, C_DISC, C_DISC, C_DISC, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL discard ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL discard counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_freeze_mispredict();
    logic [5:0] ev [4] = '{E_IMEM|E_DREQ|E_MISP, E_IMEM|E_DREQ|E_MISP,
                           E_IMEM|E_DREQ|E_DRSP|E_MISP, E_IMEM};
    ctrl_t      ex [4] = '{C_FREEZE, C_FREEZE, C_MISP, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL freeze_misp ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL freeze_misp counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ev [6] = '{E_MISP, E_IMEM|E_MISP, E_IMEM, E_MISP, E_IMEM|E_DREQ, E_IMEM};
    ctrl_t      ex [6] = '{C_MISP, C_MISP, C_DISC, C_MISP, C_FREEZE, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL back_to_back ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL back_to_back counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_discard();
    logic [5:0] ev [3] = '{E_MISP, E_RST, E_IMEM};
    ctrl_t      ex [3] = '{C_MISP, C_RST, C_NORM};
    ctrl_t e;
    logic [15:0] es, ef;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ev[i], ex[i]);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL reset_discard ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL reset_discard counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    ctrl_t e;
    logic [15:0] es, ef;
    force dut.u_stall_count.r_count = 16'hFFFE;
    #1;
    release dut.u_stall_count.r_count;
    stallModel = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(E_NONE, C_IWAIT);
      #2;
      e = expQ.pop_front();
      vectors++;
      if (actualCtrl() !== e) begin
        $display("[TB] FAIL saturation ctrl step %0d: got %b want %b", i, actualCtrl(), e);
        miscompares++;
      end
      @(posedge clk); #1;
      es = stallQ.pop_front(); ef = flushQ.pop_front();
      vectors++;
      if ({stallCount, flushCount} !== {es, ef}) begin
        $display("[TB] FAIL saturation counters step %0d: got %h/%h want %h/%h", i, stallCount, flushCount, es, ef);
        miscompares++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stallModel  = '0;
    flushModel  = '0;
    reset       = 1'b1;
    imemResp    = 1'b0;
    dmemReq     = 1'b0;
    dmemResp    = 1'b0;
    loadUse     = 1'b0;
    mispredict  = 1'b0;
    test_reset();
    test_freeze();
    test_load_use();
    test_mispredict_discard();
    test_freeze_mispredict();
    test_back_to_back();
    test_reset_in_discard();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CW = 16: width of the stall and flush event counters.
REQ-002 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, in, 1: asynchronous, active-high reset.
REQ-004 Port imem_resp, in, 1: instruction fetch data valid this cycle; fetch always requests.
REQ-005 Port dmem_req, in, 1: MEM-stage instruction is accessing data memory.
REQ-006 Port dmem_resp, in, 1: data access completes this cycle.
REQ-007 Port load_use, in, 1: ID instruction sources the destination of an EX-stage load.
REQ-008 Port mispredict, in, 1: branch resolved in MEM stage disagrees with its prediction.
REQ-009 Ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, out, 1 each: stage register load enables.
REQ-010 Ports flush_if_id, flush_id_ex, flush_ex_mem, out, 1 each: drive each register's synchronous reset input, inserting a bubble.
REQ-011 Port pc_redirect, out, 1: PC mux selects the resolved branch target.
REQ-012 Ports stall_count, flush_count, out, CW each: saturating event counters.

Function
REQ-013 FSM states: RUN, DISCARD; outputs combinational from state and inputs.
REQ-014 Per-cycle priority: dmem freeze > mispredict > load_use > imem wait.
REQ-015 Freeze (dmem_req=1, dmem_resp=0): all load_* = 0, all flush_* = 0, pc_redirect = 0.
REQ-016 Mispredict (no freeze): load_pc=1, pc_redirect=1, all loads=1, flush_if_id=flush_id_ex=flush_ex_mem=1.
REQ-017 Mispredict asserted during freeze is acted on in the first non-freeze cycle; no latch is needed because ex_mem holds.
REQ-018 Load_use (no freeze, no mispredict): load_pc=0, load_if_id=0, flush_id_ex=1, load_id_ex=1, load_ex_mem=load_mem_wb=1.
REQ-019 Imem wait in RUN (imem_resp=0, no higher event): load_pc=0, flush_if_id=1, downstream loads=1.
REQ-020 Normal RUN cycle: all loads 1, all flushes 0, pc_redirect 0.
REQ-021 RUN -> DISCARD when a mispredict is acted on and imem_resp=0 that cycle, because a stale fetch is in flight.
REQ-022 In DISCARD: load_pc=0, flush_if_id=1; downstream stages follow REQ-015/018 rules.
REQ-023 DISCARD -> RUN on imem_resp=1, even during freeze; that response is dropped.
REQ-024 A mispredict while in DISCARD redirects again per REQ-016 and remains in DISCARD.
REQ-025 stall_count increments by 1 on each non-reset cycle with load_pc=0 and saturates at all-ones.
REQ-026 flush_count increments by 1 per cycle with pc_redirect=1 and saturates at all-ones.

Reset
REQ-027 Reset asynchronously forces state=RUN, stall_count=0, flush_count=0.
REQ-028 While reset is high: all load_* = 0, all flush_* = 1, pc_redirect = 0.
REQ-029 Reset mid-DISCARD abandons the discard; the first post-reset cycle is RUN.

Structure
REQ-030 The pipe_ctrl_state_t enum (RUN, DISCARD) SHALL reside in lc3b_types.
REQ-031 A sub-module sat_counter #(CW), with enable and async reset, SHALL be instantiated twice for the two counters.
REQ-032 No other sub-modules; the stage registers remain external.

Verification
REQ-033 Cycles 0-1 with reset=1, then no events for cycles 2-4 -> cycles 0-1: loads 0, flushes 1; cycles 2-4: all loads 1, counters 0.
REQ-034 dmem_req=1 with dmem_resp=0 for 3 cycles, then dmem_resp=1 -> 3 cycles all loads 0, then loads 1; stall_count=3.
REQ-035 load_use=1 for 1 cycle -> load_pc=0, load_if_id=0, flush_id_ex=1; stall_count=1.
REQ-036 mispredict=1 with imem_resp=0, then imem_resp=0 for 2 cycles, then imem_resp=1 -> redirect cycle with flush_count=1 and state DISCARD; load_pc=0 for the next 3 cycles; RUN after the response is dropped.
REQ-037 mispredict=1 during a 2-cycle freeze -> no redirect while frozen; redirect plus 3 flushes in the release cycle.
REQ-038 Preload stall_count to 16'hFFFE via 3 imem-wait cycles -> count holds at 16'hFFFF.
